hdu_scoreboard: RTL

Parametrised hazard detection unit for the five-stage pipeline. It replaces fixed register-compare hazard logic with a per-register readiness scoreboard, a control-shadow state machine and a memory-stall freeze. The block sits beside decode. It consumes the decoded instruction's register usage, branch resolution from execute and the data-cache stall. It drives the PC, IF/ID, ID/EX and EX/MEM enable and NOP controls.

---
 rtl/hdu_pkg.sv | 25 ++
 rtl/hdu_reg_counters.sv | 43 ++++
 rtl/hdu_scoreboard.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hdu_pkg.sv
// Shared types and helpers for the hazard detection unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hdu_pkg;

  // Control-shadow state: either free to issue, or waiting for execute to resolve.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RES = 1'b1
  } ctrl_state_e;

  // Opcode of the instruction word the pipeline registers hold when bubbled/flushed.
  localparam logic [5:0] NOP_OPCODE = 6'h00;

  // Ceiling log2 for sizing counters; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hdu_reg_counters.sv
// Per-register readiness counters: loaded on issue, counted down to zero.
// Latency: set value visible on busy the cycle after the set; busy is combinational from the counters.
// Backpressure: freeze holds every counter (memory stall); a set wins over the same counter's decrement.
module hdu_reg_counters
  import hdu_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 1,
  localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic [CNT_W-1:0]      set_val,
  output logic [NUM_REGS-1:0]   busy
);

  logic [CNT_W-1:0] cnt [NUM_REGS];

  // Counter update: clear on reset, hold on freeze, otherwise set or saturating decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && (set_idx == REG_ADDR_W'(i))) begin
          cnt[i] <= set_val;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // A register is busy while its result is not yet forwardable.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (cnt[i] != '0);
  end

endmodule

// File: rtl/hdu_scoreboard.sv
// Hazard detection unit: scoreboard data hazards, control shadow FSM and memory-stall freeze.
// Latency: all outputs combinational from registered state and current inputs (zero cycles).
// Backpressure: mem_stall freezes everything and wins over control, which wins over data; HDU_PREDICT_NT_EN selects fetch-through not-taken.
module hdu_scoreboard
  import hdu_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ALU_LAT    = 0,
  parameter int LD_LAT     = 1,
  parameter int BR_TIMEOUT = 4,
  localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  rs_valid,
  input  logic                  rt_valid,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  wr_valid,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  is_load,
  input  logic                  is_ctrl,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic                  mem_stall,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  bubble_e,
  output logic                  flush_fd,
  output logic                  mem_hold,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  ctrl_err
);

  localparam int MAX_LAT   = (ALU_LAT > LD_LAT) ? ALU_LAT : LD_LAT;
  localparam int CNT_BITS  = clog2(MAX_LAT + 1);
  localparam int CNT_W     = (CNT_BITS < 1) ? 1 : CNT_BITS;
  localparam int TMR_BITS  = clog2(BR_TIMEOUT + 1);
  localparam int TMR_W     = (TMR_BITS < 1) ? 1 : TMR_BITS;

  ctrl_state_e        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               ctrl_err_q, ctrl_err_d;
  logic [NUM_REGS-1:0] busy_raw;
  logic               raw_haz;
  logic               accept;

  assign raw_haz = issue_valid & ((rs_valid & busy_raw[rs]) | (rt_valid & busy_raw[rt]));
  assign accept  = issue_valid & ~raw_haz & ~mem_stall & (state_q == IDLE);

  hdu_reg_counters #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_counters (
    .clk     (clk),
    .rst     (rst),
    .freeze  (mem_stall),
    .set_en  (accept & wr_valid),
    .set_idx (rd),
    .set_val (is_load ? CNT_W'(LD_LAT) : CNT_W'(ALU_LAT)),
    .busy    (busy_raw)
  );

`ifndef HDU_PREDICT_NT_EN
  // Fetch is stalled on every branch regardless of direction, so the taken flag carries no information here.
  logic unused_resolve_taken;
  assign unused_resolve_taken = resolve_taken;
`endif

  // Control FSM state, resolution timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  // Next-state logic (frozen under mem_stall) and prioritised pipeline controls.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ctrl_err_d = ctrl_err_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_e   = 1'b0;
    flush_fd   = 1'b0;
    mem_hold   = 1'b0;

    if (!mem_stall) begin
      case (state_q)
        IDLE: begin
          if (accept && is_ctrl) begin
            state_d = WAIT_RES;
            timer_d = '0;
          end
        end
        WAIT_RES: begin
          // A resolution in the last allowed cycle still beats the timeout.
          if (resolve_valid) begin
            state_d = IDLE;
          end else if (timer_q == TMR_W'(BR_TIMEOUT - 1)) begin
            state_d    = IDLE;
            ctrl_err_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are forced quiet while reset is held.
    if (rst) begin
      if (mem_stall) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        mem_hold = 1'b1;
      end else if (state_q == WAIT_RES) begin
`ifdef HDU_PREDICT_NT_EN
        if (resolve_valid && resolve_taken) begin
          flush_fd = 1'b1;
          bubble_e = 1'b1;
        end else if (raw_haz) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end
`else
        stall_f  = 1'b1;
        flush_fd = 1'b1;
`endif
      end else if (raw_haz) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_e = 1'b1;
      end
    end
  end

  assign busy     = rst ? busy_raw : '0;
  assign ctrl_err = rst & ctrl_err_q;

endmodule
